mod_enc_add_round_key: RTL and testbench

//  Encryption AddRoundKey stage: XORs the 128-bit state from the mixColumns stage (or from
//  the input/shiftRows path for rounds 0 and NR) with the round key from key expansion.

---
 rtl/mod_enc_add_round_key.sv | 103 ++++++++++
 tb/tb_mod_enc_add_round_key.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mod_enc_add_round_key.sv
// AES encryption AddRoundKey stage: joins state and round-key streams, XORs them,
// tags the result with its round number and holds up to two results for downstream.
module mod_enc_add_round_key #(
    parameter int N  = 16,
    parameter int NR = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N-1:0][7:0] state_in,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N-1:0][7:0] rk_in,
    input  logic              rk_valid,
    output logic              rk_ready,
    input  logic              round_clr,
    output logic [N-1:0][7:0] state_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        out_round,
    output logic              out_last
);

    localparam logic [3:0] LAST_ROUND = 4'(NR);

    logic [3:0]        rnd_cnt;
    logic [3:0]        rnd;
    logic [N-1:0][7:0] new_state;
    logic [N-1:0][7:0] skid_state;
    logic [3:0]        skid_round;
    logic              skid_last;
    logic              skid_valid;
    logic              space;
    logic              fire;
    logic              pop;

    // The output register is the FIFO head and the skid register is the second slot,
    // so space depends only on flops and never on out_ready.
    assign space     = !(out_valid && skid_valid);
    assign in_ready  = reset && rk_valid && space;
    assign rk_ready  = reset && in_valid && space;
    assign fire      = reset && in_valid && rk_valid && space;
    assign pop       = out_valid && out_ready;
    assign rnd       = round_clr ? 4'd0 : rnd_cnt;
    assign new_state = state_in ^ rk_in;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rnd_cnt <= 4'd0;
        end else if (fire) begin
            if (round_clr) begin
                rnd_cnt <= 4'd1;
            end else if (rnd == LAST_ROUND) begin
                rnd_cnt <= 4'd0;
            end else begin
                rnd_cnt <= rnd + 4'd1;
            end
        end else if (round_clr) begin
            rnd_cnt <= 4'd0;
        end
    end

    // When the head is free (empty or popping) it refills from the skid slot first,
    // which keeps results in order; otherwise a new result parks in the skid slot.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_out  <= '0;
            out_round  <= 4'd0;
            out_last   <= 1'b0;
            out_valid  <= 1'b0;
            skid_state <= '0;
            skid_round <= 4'd0;
            skid_last  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (!out_valid || pop) begin
            if (skid_valid) begin
                state_out <= skid_state;
                out_round <= skid_round;
                out_last  <= skid_last;
                out_valid <= 1'b1;
                if (fire) begin
                    skid_state <= new_state;
                    skid_round <= rnd;
                    skid_last  <= (rnd == LAST_ROUND);
                end else begin
                    skid_valid <= 1'b0;
                end
            end else if (fire) begin
                state_out <= new_state;
                out_round <= rnd;
                out_last  <= (rnd == LAST_ROUND);
                out_valid <= 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (fire) begin
            skid_state <= new_state;
            skid_round <= rnd;
            skid_last  <= (rnd == LAST_ROUND);
            skid_valid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mod_enc_add_round_key.sv
// Scoreboard bench for mod_enc_add_round_key: directed transfers push expected results,
// a monitor pops and compares whenever the DUT hands a result downstream.
module tb_mod_enc_add_round_key;

    typedef struct {
        logic [127:0] data;
        logic [3:0]   round;
        logic         last;
    } exp_t;

    logic               clk = 1'b0;
    logic               reset;
    logic [15:0][7:0]   state_in;
    logic               in_valid;
    logic               in_ready;
    logic [15:0][7:0]   rk_in;
    logic               rk_valid;
    logic               rk_ready;
    logic               round_clr;
    logic [15:0][7:0]   state_out;
    logic               out_valid;
    logic               out_ready;
    logic [3:0]         out_round;
    logic               out_last;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    mod_enc_add_round_key #(.N(16), .NR(14)) dut (
        .clk(clk), .reset(reset),
        .state_in(state_in), .in_valid(in_valid), .in_ready(in_ready),
        .rk_in(rk_in), .rk_valid(rk_valid), .rk_ready(rk_ready),
        .round_clr(round_clr),
        .state_out(state_out), .out_valid(out_valid), .out_ready(out_ready),
        .out_round(out_round), .out_last(out_last)
    );

    always #5 clk = ~clk;

    // FIPS-197 writes byte 0 first; in the packed port byte 0 is the low byte.
    function automatic logic [127:0] fips(input logic [127:0] h);
        logic [127:0] r;
        for (int k = 0; k < 16; k++) r[8*k +: 8] = h[127-8*k -: 8];
        return r;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic transfer(input logic [127:0] st, input logic [127:0] rk,
                            input logic [127:0] exp_data, input logic clr,
                            input logic [3:0] exp_rnd, output int waits);
        exp_t e;
        state_in  = st;
        rk_in     = rk;
        round_clr = clr;
        in_valid  = 1'b1;
        rk_valid  = 1'b1;
        waits     = 0;
        #1;
        while (!in_ready && waits < 50) begin
            @(posedge clk); #2;
            waits++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL transfer_timeout: in_ready stayed 0 for %0d cycles", waits);
        end else begin
            e.data  = exp_data;
            e.round = exp_rnd;
            e.last  = (exp_rnd == 4'd14);
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        rk_valid  = 1'b0;
        round_clr = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: %0d results still pending, required 0", exp_q.size());
        end
    endtask

    // Monitor: every handshake downstream must match the oldest expected result.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_output: got %h round %0d, required none",
                             state_out, out_round);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", state_out, e.data);
                    check("out_round", 128'(out_round), 128'(e.round));
                    check("out_last", 128'(out_last), 128'(e.last));
                end
            end
        end
    end

    initial begin
        int w;
        reset     = 1'b0;
        state_in  = '0;
        rk_in     = '0;
        in_valid  = 1'b1;
        rk_valid  = 1'b1;
        round_clr = 1'b0;
        out_ready = 1'b1;

        // Reset state, with both valids asserted to show the readies are held low.
        #12;
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_state_out", state_out, 128'd0);
        check("rst_out_round", 128'(out_round), 128'd0);
        check("rst_out_last", 128'(out_last), 128'd0);
        check("rst_in_ready", 128'(in_ready), 128'd0);
        check("rst_rk_ready", 128'(rk_ready), 128'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        rk_valid = 1'b0;
        reset    = 1'b1;
        @(posedge clk); #1;

        // FIPS-197 C.3 round 0 with one-cycle latency.
        transfer(fips(128'h00112233445566778899aabbccddeeff),
                 fips(128'h000102030405060708090a0b0c0d0e0f),
                 fips(128'h00102030405060708090a0b0c0d0e0f0), 1'b1, 4'd0, w);
        check("c3_latency_valid", 128'(out_valid), 128'd1);
        check("c3_latency_data", state_out, fips(128'h00102030405060708090a0b0c0d0e0f0));
        drain();

        // Back-pressure: two entries fill the buffer, the third waits.
        out_ready = 1'b0;
        transfer({16{8'haa}}, {16{8'h55}}, {16{8'hff}}, 1'b1, 4'd0, w);
        transfer({16{8'h12}}, {16{8'h34}}, {16{8'h26}}, 1'b0, 4'd1, w);
        state_in = {16{8'hf0}};
        rk_in    = {16{8'h3c}};
        in_valid = 1'b1;
        rk_valid = 1'b1;
        #1;
        check("bp_in_ready_full", 128'(in_ready), 128'd0);
        check("bp_rk_ready_full", 128'(rk_ready), 128'd0);
        @(posedge clk); #1;
        check("bp_hold_valid", 128'(out_valid), 128'd1);
        check("bp_hold_data", state_out, {16{8'hff}});
        check("bp_hold_round", 128'(out_round), 128'd0);
        out_ready = 1'b1;
        #1;
        check("bp_no_comb_ready", 128'(in_ready), 128'd0);
        @(posedge clk); #1;
        check("bp_space_back", 128'(in_ready), 128'd1);
        transfer({16{8'hf0}}, {16{8'h3c}}, {16{8'hcc}}, 1'b0, 4'd2, w);
        check("bp_third_waits", 128'(w), 128'd0);
        drain();

        // Round wrap over 16 back-to-back transfers.
        for (int i = 0; i < 16; i++) begin
            logic [7:0] b;
            b = 8'(i);
            transfer({16{b}}, {16{8'h80}}, {16{b ^ 8'h80}}, (i == 0), 4'(i % 15), w);
            if (i > 0) check("wrap_throughput", 128'(w), 128'd0);
        end
        drain();

        // Stream skew: the key arrives three cycles after the state.
        state_in = {16{8'h5a}};
        rk_in    = {16{8'h0f}};
        in_valid = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("skew_in_ready", 128'(in_ready), 128'd0);
            check("skew_rk_ready", 128'(rk_ready), 128'd1);
            @(posedge clk); #1;
        end
        transfer({16{8'h5a}}, {16{8'h0f}}, {16{8'h55}}, 1'b0, 4'd1, w);
        check("skew_fire_now", 128'(w), 128'd0);
        drain();

        // round_clr during a transfer at counter 7.
        for (int i = 2; i < 7; i++)
            transfer({16{8'h01}}, {16{8'h02}}, {16{8'h03}}, 1'b0, 4'(i), w);
        transfer({16{8'h77}}, {16{8'h11}}, {16{8'h66}}, 1'b1, 4'd0, w);
        transfer({16{8'h77}}, {16{8'h22}}, {16{8'h55}}, 1'b0, 4'd1, w);
        drain();

        // Asynchronous reset between edges with two entries buffered.
        out_ready = 1'b0;
        transfer({16{8'h0a}}, {16{8'h0b}}, {16{8'h01}}, 1'b0, 4'd2, w);
        transfer({16{8'h0c}}, {16{8'h0d}}, {16{8'h01}}, 1'b0, 4'd3, w);
        #2;
        reset = 1'b0;
        #1;
        check("arst_out_valid", 128'(out_valid), 128'd0);
        check("arst_state_out", state_out, 128'd0);
        exp_q.delete();
        out_ready = 1'b1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        transfer({16{8'hc3}}, {16{8'h3c}}, {16{8'hff}}, 1'b0, 4'd0, w);
        drain();
        repeat (2) @(posedge clk);
        #1;
        check("idle_out_valid", 128'(out_valid), 128'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
